// File: rtl/axi4_burst_arbiter.sv
// Burst-level scheduler sharing one AXI4 master port between two requesters.
// Produces registered one-hot write/read grants held for a whole burst, plus error/watchdog flags.
module axi4_burst_arbiter #(
    parameter int unsigned EXCLUSIVE   = 0,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned LEN_W       = 8
) (
    input  logic             axi_aclk,
    input  logic             rst,
    input  logic             s00_awvalid,
    input  logic             s01_awvalid,
    input  logic             s00_arvalid,
    input  logic             s01_arvalid,
    input  logic             m00_awvalid,
    input  logic             m00_awready,
    input  logic [LEN_W-1:0] m00_awlen,
    input  logic             m00_wvalid,
    input  logic             m00_wready,
    input  logic             m00_wlast,
    input  logic             m00_bvalid,
    input  logic             m00_bready,
    input  logic             m00_arvalid,
    input  logic             m00_arready,
    input  logic             m00_rvalid,
    input  logic             m00_rready,
    input  logic             m00_rlast,
    output logic [1:0]       wr_grant,
    output logic [1:0]       rd_grant,
    output logic             wr_len_err,
    output logic             wr_timeout,
    output logic             rd_timeout
);

    localparam int unsigned    WD_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
    localparam bit             WD_EN  = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {StWrIdle, StWrAddr, StWrData, StWrResp} wr_state_t;
    typedef enum logic [1:0] {StRdIdle, StRdAddr, StRdData} rd_state_t;

    wr_state_t         wr_state_q;
    rd_state_t         rd_state_q;
    logic [1:0]        wr_grant_q, rd_grant_q;
    logic              wr_prio_q, rd_prio_q;   // 1 = s01 wins the next tie
    logic              rw_ptr_q;               // 1 = read wins the next exclusive tie
    logic [LEN_W:0]    beat_cnt_q;
    logic [LEN_W-1:0]  awlen_q;
    logic              wr_len_err_q, wr_timeout_q, rd_timeout_q;
    logic [WD_W-1:0]   wr_wd_q, rd_wd_q;

    logic              wr_req, rd_req, wr_idle, rd_idle, wr_start, rd_start;
    logic [1:0]        wr_pick, rd_pick;
    logic [WD_W-1:0]   wr_wd_inc, rd_wd_inc;
    logic              wr_expire, rd_expire, wr_wd_hit, rd_wd_hit;

    always_comb begin
        wr_req  = s00_awvalid | s01_awvalid;
        rd_req  = s00_arvalid | s01_arvalid;
        wr_idle = (wr_state_q == StWrIdle);
        rd_idle = (rd_state_q == StRdIdle);
        if (EXCLUSIVE != 0) begin
            wr_start = wr_idle && wr_req && rd_idle && (!rd_req || !rw_ptr_q);
            rd_start = rd_idle && rd_req && wr_idle && (!wr_req || rw_ptr_q);
        end else begin
            wr_start = wr_idle && wr_req;
            rd_start = rd_idle && rd_req;
        end

        if (s00_awvalid && s01_awvalid) wr_pick = wr_prio_q ? 2'b10 : 2'b01;
        else if (s00_awvalid)           wr_pick = 2'b01;
        else                            wr_pick = 2'b10;
        if (s00_arvalid && s01_arvalid) rd_pick = rd_prio_q ? 2'b10 : 2'b01;
        else if (s00_arvalid)           rd_pick = 2'b01;
        else                            rd_pick = 2'b10;

        // Flag is raised on reaching the limit; the FSM is released one cycle later.
        wr_wd_inc = wr_wd_q + WD_W'(1);
        rd_wd_inc = rd_wd_q + WD_W'(1);
        wr_wd_hit = WD_EN && !wr_idle && (wr_wd_inc == WD_MAX);
        rd_wd_hit = WD_EN && !rd_idle && (rd_wd_inc == WD_MAX);
        wr_expire = WD_EN && !wr_idle && (wr_wd_q == WD_MAX);
        rd_expire = WD_EN && !rd_idle && (rd_wd_q == WD_MAX);
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            rw_ptr_q <= 1'b0;
        end else if (wr_start) begin
            rw_ptr_q <= 1'b1;
        end else if (rd_start) begin
            rw_ptr_q <= 1'b0;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            wr_state_q   <= StWrIdle;
            wr_grant_q   <= 2'b00;
            wr_prio_q    <= 1'b0;
            beat_cnt_q   <= '0;
            awlen_q      <= '0;
            wr_len_err_q <= 1'b0;
            wr_timeout_q <= 1'b0;
            wr_wd_q      <= '0;
        end else begin
            if (wr_idle)                wr_wd_q <= '0;
            else if (wr_wd_q != WD_MAX) wr_wd_q <= wr_wd_inc;
            if (wr_wd_hit) wr_timeout_q <= 1'b1;

            if (wr_expire) begin
                wr_state_q <= StWrIdle;
                wr_grant_q <= 2'b00;
            end else begin
                case (wr_state_q)
                    StWrIdle: begin
                        if (wr_start) begin
                            wr_grant_q <= wr_pick;
                            wr_prio_q  <= wr_pick[0];
                            wr_state_q <= StWrAddr;
                        end
                    end
                    StWrAddr: begin
                        if (m00_awvalid && m00_awready) begin
                            awlen_q    <= m00_awlen;
                            beat_cnt_q <= '0;
                            wr_state_q <= StWrData;
                        end
                    end
                    StWrData: begin
                        if (m00_wvalid && m00_wready) begin
                            if (m00_wlast) begin
                                if (beat_cnt_q != {1'b0, awlen_q}) wr_len_err_q <= 1'b1;
                                wr_state_q <= StWrResp;
                            end else begin
                                if (beat_cnt_q == {1'b0, awlen_q}) wr_len_err_q <= 1'b1;
                                beat_cnt_q <= beat_cnt_q + 1'b1;
                            end
                        end
                    end
                    StWrResp: begin
                        if (m00_bvalid && m00_bready) begin
                            wr_state_q <= StWrIdle;
                            wr_grant_q <= 2'b00;
                        end
                    end
                    default: begin
                        wr_state_q <= StWrIdle;
                        wr_grant_q <= 2'b00;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            rd_state_q   <= StRdIdle;
            rd_grant_q   <= 2'b00;
            rd_prio_q    <= 1'b0;
            rd_timeout_q <= 1'b0;
            rd_wd_q      <= '0;
        end else begin
            if (rd_idle)                rd_wd_q <= '0;
            else if (rd_wd_q != WD_MAX) rd_wd_q <= rd_wd_inc;
            if (rd_wd_hit) rd_timeout_q <= 1'b1;

            if (rd_expire) begin
                rd_state_q <= StRdIdle;
                rd_grant_q <= 2'b00;
            end else begin
                case (rd_state_q)
                    StRdIdle: begin
                        if (rd_start) begin
                            rd_grant_q <= rd_pick;
                            rd_prio_q  <= rd_pick[0];
                            rd_state_q <= StRdAddr;
                        end
                    end
                    StRdAddr: begin
                        if (m00_arvalid && m00_arready) rd_state_q <= StRdData;
                    end
                    StRdData: begin
                        if (m00_rvalid && m00_rready && m00_rlast) begin
                            rd_state_q <= StRdIdle;
                            rd_grant_q <= 2'b00;
                        end
                    end
                    default: begin
                        rd_state_q <= StRdIdle;
                        rd_grant_q <= 2'b00;
                    end
                endcase
            end
        end
    end

    assign wr_grant   = wr_grant_q;
    assign rd_grant   = rd_grant_q;
    assign wr_len_err = wr_len_err_q;
    assign wr_timeout = wr_timeout_q;
    assign rd_timeout = rd_timeout_q;

endmodule
